// File: rtl/rv_iopmp_axi4_burst_split.sv
// rtl/rv_iopmp_axi4_burst_split.sv - splits a linear transfer into AXI4 INCR bursts that never cross 4 KiB
// Optional feature macro: RV_IOPMP_BURST_SPLIT_ALIGN_CHECK_EN (reject misaligned start addresses)

package axi_pkg;
  typedef logic [2:0] size_t;
  typedef logic [7:0] len_t;
  typedef logic [1:0] burst_t;
  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;
endpackage

module rv_iopmp_axi4_burst_split #(
  parameter int ADDR_WIDTH = 64,
  parameter int MAX_BEATS  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [15:0]           req_beats_i,
  input  axi_pkg::size_t        req_size_i,
  output logic                  ax_valid_o,
  input  logic                  ax_ready_i,
  output logic [ADDR_WIDTH-1:0] ax_addr_o,
  output axi_pkg::len_t         ax_len_o,
  output axi_pkg::size_t        ax_size_o,
  output axi_pkg::burst_t       ax_burst_o,
  output logic                  ax_last_o,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [16:0]           rem_q;
  axi_pkg::size_t        size_q;
  logic                  err_q;

  logic                  accept, reject, issuing, hs, last_burst;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic [12:0]           to_bound;
  logic [16:0]           beats;

  assign issuing    = (state_q == ISSUE);
  assign accept     = req_valid_i && (state_q == IDLE);
  assign align_mask = ~({ADDR_WIDTH{1'b1}} << req_size_i);

`ifdef RV_IOPMP_BURST_SPLIT_ALIGN_CHECK_EN
  assign reject = (req_size_i > 3'd3) || (|(req_addr_i & align_mask));
`else
  assign reject = (req_size_i > 3'd3);
`endif

  // Beats left before the next 4 KiB page; an exactly aligned address sees the whole page.
  assign to_bound = (13'd4096 - {1'b0, addr_q[11:0]}) >> size_q;

  always_comb begin
    beats = rem_q;
    if ({4'b0, to_bound} < beats) beats = {4'b0, to_bound};
    if (17'(MAX_BEATS) < beats)   beats = 17'(MAX_BEATS);
  end

  assign last_burst = (beats == rem_q);
  assign hs         = ax_valid_o && ax_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !reject) state_d = ISSUE;
      ISSUE:   if (hs && last_burst)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered burst state only moves on acceptance or handshake, so ax_* hold while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      rem_q  <= '0;
      size_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && reject;
      if (accept && !reject) begin
        addr_q <= req_addr_i & ~align_mask;
        rem_q  <= {1'b0, req_beats_i} + 17'd1;
        size_q <= req_size_i;
      end else if (hs) begin
        addr_q <= addr_q + (ADDR_WIDTH'(beats) << size_q);
        rem_q  <= rem_q - beats;
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = issuing;
  assign err_o       = err_q;
  assign ax_valid_o  = issuing;
  assign ax_addr_o   = issuing ? addr_q : '0;
  assign ax_len_o    = issuing ? axi_pkg::len_t'(beats - 17'd1) : '0;
  assign ax_size_o   = issuing ? size_q : '0;
  assign ax_burst_o  = axi_pkg::BURST_INCR;
  assign ax_last_o   = issuing && last_burst;

endmodule

// File: tb/tb_rv_iopmp_axi4_burst_split.sv
// tb/tb_rv_iopmp_axi4_burst_split.sv - directed self-checking bench for rv_iopmp_axi4_burst_split

module tb_rv_iopmp_axi4_burst_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [15:0] req_beats;
  logic [2:0]  req_size;
  logic        ax_valid;
  logic        ax_ready;
  logic [63:0] ax_addr;
  logic [7:0]  ax_len;
  logic [2:0]  ax_size;
  logic [1:0]  ax_burst;
  logic        ax_last;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rv_iopmp_axi4_burst_split #(.ADDR_WIDTH(64), .MAX_BEATS(256)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_beats_i (req_beats),
    .req_size_i  (req_size),
    .ax_valid_o  (ax_valid),
    .ax_ready_i  (ax_ready),
    .ax_addr_o   (ax_addr),
    .ax_len_o    (ax_len),
    .ax_size_o   (ax_size),
    .ax_burst_o  (ax_burst),
    .ax_last_o   (ax_last),
    .busy_o      (busy),
    .err_o       (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [63:0] a, input logic [15:0] b, input logic [2:0] s);
    int waited = 0;
    while (!req_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    req_beats = b;
    req_size  = s;
    tick();
    req_valid = 1'b0;
  endtask

  // Checks the burst currently presented, then completes its handshake.
  task automatic expect_burst(input string tag, input logic [63:0] a, input logic [7:0] len,
                              input logic [2:0] s, input logic last);
    chk({tag, ".valid"}, ax_valid, 1'b1);
    chk({tag, ".addr"},  ax_addr,  a);
    chk({tag, ".len"},   ax_len,   len);
    chk({tag, ".size"},  ax_size,  s);
    chk({tag, ".burst"}, ax_burst, 2'b01);
    chk({tag, ".last"},  ax_last,  last);
    chk({tag, ".busy"},  busy,     1'b1);
    ax_ready = 1'b1;
    tick();
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".ready"}, req_ready, 1'b1);
    chk({tag, ".valid"}, ax_valid,  1'b0);
    chk({tag, ".busy"},  busy,      1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_beats = '0; req_size = '0; ax_ready = 1'b1;
    tick(); tick();
    chk("rst.valid", ax_valid, 1'b0);
    chk("rst.last",  ax_last,  1'b0);
    chk("rst.busy",  busy,     1'b0);
    chk("rst.err",   err,      1'b0);
    chk("rst.addr",  ax_addr,  64'h0);
    chk("rst.len",   ax_len,   8'h0);
    chk("rst.size",  ax_size,  3'h0);
    chk("rst.burst", ax_burst, 2'b01);
    rst = 1'b0;
    tick();
    chk("rst.ready", req_ready, 1'b1);

    // Single burst on page start
    send_req(64'h1000, 16'd15, 3'd3);
    chk("single.ready_low", req_ready, 1'b0);
    expect_burst("single", 64'h1000, 8'd15, 3'd3, 1'b1);
    expect_idle("single.end");

    // Crosses a 4 KiB boundary
    send_req(64'h0FF0, 16'd3, 3'd3);
    expect_burst("cross0", 64'h0FF0, 8'd1, 3'd3, 1'b0);
    expect_burst("cross1", 64'h1000, 8'd1, 3'd3, 1'b1);
    expect_idle("cross.end");

    // MAX_BEATS-limited, back-to-back
    send_req(64'h0, 16'd1023, 3'd2);
    expect_burst("max0", 64'h000, 8'd255, 3'd2, 1'b0);
    expect_burst("max1", 64'h400, 8'd255, 3'd2, 1'b0);
    expect_burst("max2", 64'h800, 8'd255, 3'd2, 1'b0);
    expect_burst("max3", 64'hC00, 8'd255, 3'd2, 1'b1);
    expect_idle("max.end");

    // Byte-size beats across a boundary
    send_req(64'h0FFE, 16'd3, 3'd0);
    expect_burst("byte0", 64'h0FFE, 8'd1, 3'd0, 1'b0);
    expect_burst("byte1", 64'h1000, 8'd1, 3'd0, 1'b1);
    expect_idle("byte.end");

    // Stall mid-request: outputs must hold
    send_req(64'h0FF0, 16'd3, 3'd3);
    expect_burst("stall0", 64'h0FF0, 8'd1, 3'd3, 1'b0);
    ax_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall.valid", ax_valid, 1'b1);
      chk("stall.addr",  ax_addr,  64'h1000);
      chk("stall.len",   ax_len,   8'd1);
      chk("stall.size",  ax_size,  3'd3);
      chk("stall.last",  ax_last,  1'b1);
    end
    expect_burst("stall1", 64'h1000, 8'd1, 3'd3, 1'b1);
    expect_idle("stall.end");

    // Misaligned start: low address bits dropped
    send_req(64'h1004, 16'd0, 3'd3);
    chk("misal.err", err, 1'b0);
    expect_burst("misal", 64'h1000, 8'd0, 3'd3, 1'b1);
    expect_idle("misal.end");

    // Oversized beat rejected
    send_req(64'h2000, 16'd7, 3'd4);
    chk("bad.err",   err,      1'b1);
    chk("bad.valid", ax_valid, 1'b0);
    chk("bad.ready", req_ready, 1'b1);
    tick();
    chk("bad.err_pulse", err, 1'b0);
    chk("bad.valid2",    ax_valid, 1'b0);

    // Reset during the second of four bursts
    send_req(64'h0, 16'd1023, 3'd2);
    expect_burst("rmid0", 64'h000, 8'd255, 3'd2, 1'b0);
    chk("rmid1.addr", ax_addr, 64'h400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid.valid", ax_valid, 1'b0);
    chk("rmid.busy",  busy,     1'b0);
    chk("rmid.addr",  ax_addr,  64'h0);
    tick();
    expect_idle("rmid.idle");
    send_req(64'h0FF0, 16'd3, 3'd3);
    expect_burst("post0", 64'h0FF0, 8'd1, 3'd3, 1'b0);
    expect_burst("post1", 64'h1000, 8'd1, 3'd3, 1'b1);
    expect_idle("post.end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rv_iopmp_axi4_burst_split.md
RV_IOPMP_AXI4_BURST_SPLIT -- requirements
Module: rv_iopmp_axi4_burst_split

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64: width of request and AxADDR addresses.
REQ-002 SHALL have parameter MAX_BEATS, default 256: maximum beats per emitted burst (AXI4 INCR limit), power of two, 2..256.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid_i, input, 1: linear transfer request valid.
REQ-006 SHALL have port req_ready_o, output, 1: request accepted when req_valid_i && req_ready_o.
REQ-007 SHALL have port req_addr_i, input, ADDR_WIDTH: start byte address.
REQ-008 SHALL have port req_beats_i, input, 16: total beats minus one (1..65536 beats).
REQ-009 SHALL have port req_size_i, input, axi_pkg::size_t: log2 bytes per beat.
REQ-010 SHALL have port ax_valid_o, input ax_ready_i, 1 each: AxVALID/AxREADY handshake of the emitted burst.
REQ-011 SHALL have ports ax_addr_o (ADDR_WIDTH), ax_len_o (axi_pkg::len_t), ax_size_o (axi_pkg::size_t), ax_burst_o (axi_pkg::burst_t): emitted AxADDR/AxLEN/AxSIZE/AxBURST.
REQ-012 SHALL have port ax_last_o, output, 1: emitted burst is the final one of the current request.
REQ-013 SHALL have ports busy_o and err_o, output, 1 each: request in progress; one-cycle pulse on rejected request.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> IDLE; req_ready_o = 1 only in IDLE.
REQ-015 SHALL, on request acceptance, register address, remaining = req_beats_i+1 (17-bit), and size; first ax_valid_o asserts the following cycle (latency 1).
REQ-016 SHALL compute each burst: to_bound = (4096 - (addr & 0xFFF)) >> size; beats = min(remaining, to_bound, MAX_BEATS); ax_len_o = beats-1.
REQ-017 SHALL never emit a burst whose byte range crosses a 4 KiB boundary; an address exactly on a boundary yields to_bound = 4096>>size.
REQ-018 SHALL drive ax_burst_o = axi_pkg::BURST_INCR and ax_size_o = latched size for every burst.
REQ-019 SHALL hold all ax_* outputs stable while ax_valid_o && !ax_ready_i.
REQ-020 SHALL, on ax handshake with more remaining, advance addr += beats<<size, remaining -= beats, keep ax_valid_o high next cycle (back-to-back bursts, no bubble).
REQ-021 SHALL, on handshake of the burst with ax_last_o = 1, return to IDLE; req_ready_o high the next cycle.
REQ-022 SHALL reject (accept, pulse err_o, emit nothing, stay IDLE) any request with req_size_i > 3.
REQ-023 SHALL drive busy_o = 1 in ISSUE.
REQ-024 SHALL use 64-bit unsigned arithmetic for address advance; wrap past 2^ADDR_WIDTH is not checked.

Reset
REQ-025 SHALL, on rst_i high at a clock edge, enter IDLE; ax_valid_o, ax_last_o, busy_o, err_o = 0; ax_addr_o, ax_len_o, ax_size_o = 0; ax_burst_o = BURST_INCR; req_ready_o = 1 after reset deasserts.
REQ-026 SHALL discard any in-progress request on reset mid-operation; no partial burst resumes.

Configuration
REQ-027 SHALL support macro RV_IOPMP_BURST_SPLIT_ALIGN_CHECK_EN: when defined, a start address not aligned to 1<<req_size_i is rejected per REQ-022 (err_o pulse, no bursts).
REQ-028 SHALL, without RV_IOPMP_BURST_SPLIT_ALIGN_CHECK_EN, force the low req_size_i address bits to zero on acceptance and proceed normally; err_o then fires only for REQ-022.

Verification
REQ-029 SHALL cover: addr 0x1000, beats 15, size 3 -> one burst addr 0x1000, len 15, last=1.
REQ-030 SHALL cover: addr 0x0FF0, beats 3, size 3 -> bursts (0x0FF0, len 1), (0x1000, len 1, last=1).
REQ-031 SHALL cover: addr 0x0, beats 1023, size 2 -> four bursts of len 255 at 0x000, 0x400, 0x800, 0xC00; back-to-back with ax_ready_i=1.
REQ-032 SHALL cover: ax_ready_i low 5 cycles mid-request -> ax_* outputs bit-stable until handshake.
REQ-033 SHALL cover: addr 0x1004, size 3 -> with macro, err_o pulse and no ax_valid_o; without, one burst at 0x1000.
REQ-034 SHALL cover: rst_i asserted during 2nd of 4 bursts -> ax_valid_o 0 next cycle, IDLE, new request then splits correctly.
